snn_stream_driver: RTL and testbench
====================================

// Module: snn_stream_driver
// PURPOSE
// - Transmit side of the SNN input protocol: holds one test vector (2x 6x6 img, 3x3 ker, 2x2 weight) and streams it to the SNN core.
// - Streams on in_valid/img/ker/weight. Then waits for the core's out_valid/out_data and captures the 10-bit result.
// - Sits between the host/pattern loader and the SNN core. Used for on-chip self-test and for bench replay.
// PARAMETERS
// - IMG_LEN      72   img bytes per vector; two 6x6 images, row-major, image 0 first
// - KER_LEN      9    kernel bytes; driven on the first KER_LEN stream cycles
// - W_LEN        4    weight bytes; driven on the first W_LEN stream cycles
// - TIMEOUT_CYC  200  max WAIT cycles before abort; used only with SNN_DRV_TIMEOUT_EN
// PORTS
// - clk        in   1   single clock; all logic on posedge
// - rst        in   1   synchronous reset, active-high
// - wr_en      in   1   host write strobe into vector memory
// - wr_sel     in   2   0=img, 1=ker, 2=weight, 3=ignored
// - wr_addr    in   7   byte index within the selected memory
// - wr_data    in   8   byte to write
// - start      in   1   1-cycle request to stream the stored vector
// - busy       out  1   high from start acceptance until done (inclusive)
// - in_valid   out  1   to SNN core: stream qualifier
// - img        out  8   to SNN core: image byte
// - ker        out  8   to SNN core: kernel byte, 0 when not driven
// - weight     out  8   to SNN core: weight byte, 0 when not driven
// - out_valid  in   1   from SNN core: result strobe
// - out_data   in   10  from SNN core: similarity result
// - done       out  1   1-cycle pulse: result valid (or timed out)
// - result     out  10  captured out_data; held until the next start
// - proto_err  out  1   sticky: out_valid seen outside WAIT; cleared by accepted start
// - timeout    out  1   sticky: WAIT exceeded TIMEOUT_CYC; cleared by accepted start
// BEHAVIOUR
// - Reset: state=IDLE; busy, in_valid, done, proto_err, timeout = 0; img, ker, weight, result = 0; idx = 0.
//   Vector memories are not reset. Reset mid-stream drops in_valid the next cycle; there is no partial resume.
// - Writes: accepted only when busy=0. Ignored if sel=3 or addr >= the length of the selected memory.
// - FSM IDLE -> SEND -> WAIT -> DONE -> IDLE.
// - IDLE: start=1 sampled at edge T moves to SEND, sets busy, clears result, proto_err and timeout.
//   start while busy=1 is ignored.
// - SEND: idx counts 0..IMG_LEN-1. All stream outputs are registered.
//   in_valid=1 from cycle T+1 through T+IMG_LEN, contiguous with no gaps.
//   img=img_mem[idx]; ker=ker_mem[idx] if idx<KER_LEN else 0; weight=w_mem[idx] if idx<W_LEN else 0.
//   After idx=IMG_LEN-1: in_valid, img, ker, weight = 0; go to WAIT.
// - WAIT: first cycle out_valid=1 -> result<=out_data; go to DONE. out_data is captured unmodified (10 bits).
// - DONE: done=1 for exactly one cycle, busy=1 in that cycle; then IDLE with busy=0.
//   Earliest next start is the cycle after done.
// - out_valid=1 while in IDLE, SEND or DONE sets proto_err and is otherwise ignored.
// - rst has priority over every other event, including start and out_valid in the same cycle.
// CONFIGURATION
// - SNN_DRV_TIMEOUT_EN defined: a WAIT cycle counter runs.
//   If the counter reaches TIMEOUT_CYC with no out_valid: timeout<=1, result<=0, go to DONE (done pulses).
// - SNN_DRV_TIMEOUT_EN undefined: there is no counter, and WAIT holds indefinitely.
//   timeout is tied to 0; TIMEOUT_CYC is unused.
// TESTING
// - Load img[i]=i, ker[k]=8'h10+k, w[j]=8'hA0+j; pulse start -> 72 contiguous in_valid cycles, img=0..71.
//   ker=10..18 then 0; weight=A0..A3 then 0.
// - After stream, drive out_valid with out_data=10'd37 after 8 cycles -> next cycle done=1, result=37.
//   Then busy=0.
// - start pulsed at idx=20 and a write during SEND -> stream unchanged; memory contents unchanged.
// - rst asserted at idx=30 -> next cycle in_valid=0, busy=0. A new start restreams from img=0 with the old memory.
// - out_valid pulsed during SEND -> proto_err=1, stream continues. Next start clears proto_err.
// - With SNN_DRV_TIMEOUT_EN and TIMEOUT_CYC=200, no out_valid -> done and timeout=1, 200 cycles into WAIT.
//   result=0.

Source files
------------

// File: rtl/snn_stream_driver.sv
// Transmit side of the SNN input protocol. It holds one test vector and streams it to the core, then captures the 10-bit result.
// Optional feature: define SNN_DRV_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
module snn_stream_driver #(
  parameter int IMG_LEN     = 72,
  parameter int KER_LEN     = 9,
  parameter int W_LEN       = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       in_valid,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight,
  input  logic       out_valid,
  input  logic [9:0] out_data,
  output logic       done,
  output logic [9:0] result,
  output logic       proto_err,
  output logic       timeout
);

  localparam int IW = $clog2(IMG_LEN);
  localparam int KW = $clog2(KER_LEN);
  localparam int WW = $clog2(W_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [7:0]      img_mem [IMG_LEN];
  logic [7:0]      ker_mem [KER_LEN];
  logic [7:0]      w_mem   [W_LEN];

  logic [IW-1:0]   fidx;
  logic [7:0]      f_img;
  logic [7:0]      f_ker;
  logic [7:0]      f_w;

  // NOTE: the vector memories carry no reset; their contents must survive rst so a
  // new start after an aborted stream replays the same vector.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      case (wr_sel)
        2'd0: if (wr_addr < 7'(IMG_LEN)) img_mem[wr_addr[IW-1:0]] <= wr_data;
        2'd1: if (wr_addr < 7'(KER_LEN)) ker_mem[wr_addr[KW-1:0]] <= wr_data;
        2'd2: if (wr_addr < 7'(W_LEN))   w_mem[wr_addr[WW-1:0]]   <= wr_data;
        default: ;
      endcase
    end
  end

  // Element to present on the next cycle: 0 when a stream is accepted, idx+1 while sending.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fidx  = (state == S_SEND) ? idx + IW'(1) : '0;
    f_img = '0;
    f_ker = '0;
    f_w   = '0;
    if (fidx < IW'(IMG_LEN)) f_img = img_mem[fidx];
    if (fidx < IW'(KER_LEN)) f_ker = ker_mem[fidx[KW-1:0]];
    if (fidx < IW'(W_LEN))   f_w   = w_mem[fidx[WW-1:0]];
  end

`ifdef SNN_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // NOTE: all state and outputs here use non-blocking assignments, so each one holds the value from before the edge for the rest of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      in_valid  <= 1'b0;
      img       <= '0;
      ker       <= '0;
      weight    <= '0;
      done      <= 1'b0;
      result    <= '0;
      proto_err <= 1'b0;
`ifdef SNN_DRV_TIMEOUT_EN
      timeout   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SEND;
            busy      <= 1'b1;
            result    <= '0;
            proto_err <= 1'b0;
`ifdef SNN_DRV_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            idx       <= '0;
            in_valid  <= 1'b1;
            img       <= f_img;
            ker       <= f_ker;
            weight    <= f_w;
          end
        end
        S_SEND: begin
          if (idx == IW'(IMG_LEN - 1)) begin
            state    <= S_WAIT;
            in_valid <= 1'b0;
            img      <= '0;
            ker      <= '0;
            weight   <= '0;
`ifdef SNN_DRV_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            idx    <= fidx;
            img    <= f_img;
            ker    <= f_ker;
            weight <= f_w;
          end
        end
        S_WAIT: begin
          if (out_valid) begin
            result <= out_data;
            done   <= 1'b1;
            state  <= S_DONE;
          end
`ifdef SNN_DRV_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A result strobe outside WAIT is a protocol error; this wins over the clear on start.
      if (out_valid && state != S_WAIT) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snn_stream_driver.sv
// Self-checking bench for snn_stream_driver: a vector-level model is compared every cycle, and directed literal checks pin the model.
module tb_snn_stream_driver;

  localparam int IMG_LEN = 72;
  localparam int KER_LEN = 9;
  localparam int W_LEN   = 4;
  localparam int TO_CYC  = 200;
`ifdef SNN_DRV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy, in_valid, done, proto_err, timeout;
  logic [7:0] img, ker, weight;
  logic       out_valid = 1'b0;
  logic [9:0] out_data = '0;
  logic [9:0] result;

  snn_stream_driver dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .in_valid(in_valid),
    .img(img), .ker(ker), .weight(weight), .out_valid(out_valid),
    .out_data(out_data), .done(done), .result(result),
    .proto_err(proto_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector-level model ----------------
  // The transaction is described by its phase and by the stream position being presented.
  localparam int P_IDLE = 0, P_SEND = 1, P_WAIT = 2, P_DONE = 3;
  logic [7:0] sh_img [IMG_LEN];
  logic [7:0] sh_ker [KER_LEN];
  logic [7:0] sh_w   [W_LEN];
  int         m_phase = P_IDLE;
  int         m_pos = -1;
  int         m_wait = 0;
  bit         m_busy = 0, m_done = 0, m_perr = 0, m_to = 0;
  logic [9:0] m_result = '0;

  always @(posedge clk) begin
    int prev;
    prev = m_phase;
    if (rst) begin
      m_phase = P_IDLE; m_pos = -1; m_busy = 0; m_done = 0;
      m_perr = 0; m_to = 0; m_result = '0; m_wait = 0;
    end else begin
      if (wr_en && !m_busy) begin
        if (wr_sel == 2'd0 && wr_addr < IMG_LEN) sh_img[wr_addr] = wr_data;
        if (wr_sel == 2'd1 && wr_addr < KER_LEN) sh_ker[wr_addr] = wr_data;
        if (wr_sel == 2'd2 && wr_addr < W_LEN)   sh_w[wr_addr]   = wr_data;
      end
      m_done = 0;
      if (prev == P_IDLE && start) begin
        m_phase = P_SEND; m_pos = 0; m_busy = 1;
        m_result = '0; m_perr = 0; m_to = 0;
      end else if (prev == P_SEND) begin
        if (m_pos == IMG_LEN - 1) begin
          m_pos = -1; m_phase = P_WAIT; m_wait = 0;
        end else m_pos++;
      end else if (prev == P_WAIT) begin
        m_wait++;
        if (out_valid) begin
          m_result = out_data; m_done = 1; m_phase = P_DONE;
        end else if (TO_EN && m_wait == TO_CYC) begin
          m_to = 1; m_result = '0; m_done = 1; m_phase = P_DONE;
        end
      end else if (prev == P_DONE) begin
        m_busy = 0; m_phase = P_IDLE;
      end
      if (out_valid && prev != P_WAIT) m_perr = 1;
    end
  end

  // One compare process: every output checked against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("in_valid", in_valid, m_pos >= 0);
      check("img", img, (m_pos >= 0) ? sh_img[m_pos] : 8'h00);
      check("ker", ker, (m_pos >= 0 && m_pos < KER_LEN) ? sh_ker[m_pos] : 8'h00);
      check("weight", weight, (m_pos >= 0 && m_pos < W_LEN) ? sh_w[m_pos] : 8'h00);
      check("done", done, m_done);
      check("result", result, m_result);
      check("proto_err", proto_err, m_perr);
      check("timeout", timeout, m_to);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [6:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic result_strobe(input logic [9:0] d);
    out_valid = 1'b1; out_data = d;
    tick();
    out_valid = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset busy", busy, 0);
    check("reset in_valid", in_valid, 0);
    check("reset result", result, 0);

    // Load the vector, plus writes that must be ignored.
    for (int i = 0; i < IMG_LEN; i++) wr(2'd0, 7'(i), 8'(i));
    for (int i = 0; i < KER_LEN; i++) wr(2'd1, 7'(i), 8'h10 + 8'(i));
    for (int i = 0; i < W_LEN; i++)   wr(2'd2, 7'(i), 8'hA0 + 8'(i));
    wr(2'd3, 7'd0, 8'hEE);
    wr(2'd0, 7'd72, 8'hEE);
    wr(2'd1, 7'd9, 8'hEE);
    wr(2'd2, 7'd4, 8'hEE);

    // Result strobe while idle flags a protocol error.
    result_strobe(10'd5);
    check("idle out_valid perr", proto_err, 1);

    // Basic stream: 72 contiguous elements.
    do_start();
    check("s0 perr cleared", proto_err, 0);
    check("s0 img", img, 8'h00);
    check("s0 ker", ker, 8'h10);
    check("s0 weight", weight, 8'hA0);
    repeat (3) tick();
    check("s3 weight", weight, 8'hA3);
    tick();
    check("s4 weight", weight, 8'h00);
    repeat (4) tick();
    check("s8 ker", ker, 8'h18);
    tick();
    check("s9 ker", ker, 8'h00);
    repeat (IMG_LEN - 1 - 9) tick();
    check("s71 img", img, 8'd71);
    check("s71 valid", in_valid, 1);
    tick();
    check("after stream valid", in_valid, 0);
    repeat (7) tick();
    result_strobe(10'd37);
    check("done pulse", done, 1);
    check("result 37", result, 10'd37);
    check("busy in done", busy, 1);
    tick();
    check("busy after done", busy, 0);
    check("done one cycle", done, 0);

    // start and write during SEND are ignored; start during DONE is ignored.
    do_start();
    repeat (20) tick();
    start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 7'd5; wr_data = 8'hFF;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("s21 img", img, 8'd21);
    repeat (IMG_LEN - 1 - 21) tick();
    tick();
    repeat (2) tick();
    result_strobe(10'h3FF);
    check("result full width", result, 10'h3FF);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start in done ignored", busy, 0);

    // Reset mid-stream, together with start and out_valid.
    do_start();
    repeat (30) tick();
    check("s30 img", img, 8'd30);
    rst = 1'b1; start = 1'b1; out_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; out_valid = 1'b0;
    check("rst drops valid", in_valid, 0);
    check("rst drops busy", busy, 0);
    check("rst beats out_valid", proto_err, 0);

    // Restream from element 0 with the old memory; strobe during SEND.
    do_start();
    check("restream img0", img, 8'h00);
    repeat (5) tick();
    check("mem unchanged img5", img, 8'd5);
    repeat (35) tick();
    out_valid = 1'b1; out_data = 10'd9;
    tick();
    out_valid = 1'b0;
    check("send strobe perr", proto_err, 1);
    check("stream continues", img, 8'd41);
    repeat (IMG_LEN - 1 - 41) tick();
    tick();
    result_strobe(10'h155);
    check("result 341", result, 10'd341);
    tick();

    // No result: timeout build aborts after TO_CYC wait cycles, otherwise WAIT holds.
    do_start();
    check("perr cleared by start", proto_err, 0);
    repeat (IMG_LEN - 1) tick();
    tick();
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
    if (TO_EN) begin
      check("timeout done cycle", k, TO_CYC);
      check("timeout flag", timeout, 1);
      check("timeout result", result, 0);
      tick();
    end else begin
      check("wait holds no done", k, 0);
      check("wait holds busy", busy, 1);
      result_strobe(10'd999);
      check("late result", result, 10'd999);
      tick();
    end
    check("final idle", busy, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
